// File: rtl/cmd_sequencer_if.sv
// Command/response handshake between the UART/BLE command receiver and the sequencer.
// master = receiver side, slave = sequencer side.
interface cmd_sequencer_if;
    logic        cmd_rdy;
    logic [7:0]  cmd;
    logic [15:0] data;
    logic        clr_cmd_rdy;
    logic        send_resp;
    logic [7:0]  resp;
    logic        resp_sent;

    modport master (
        output cmd_rdy, cmd, data, resp_sent,
        input  clr_cmd_rdy, send_resp, resp
    );

    modport slave (
        input  cmd_rdy, cmd, data, resp_sent,
        output clr_cmd_rdy, send_resp, resp
    );
endinterface

// File: rtl/cmd_sequencer.sv
// Host command decoder: owns the flight setpoints, sequences motor spin-up and
// inertial calibration, and returns a one-byte ACK/NAK for every command.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for cmd_rdy; decodes and consumes a command
// SPINUP   | motors at calibration speed, counting 2^SPINUP_W cycles
// CAL      | calibration started, waiting for cal_done
// ACK_WAIT | response launched, waiting for resp_sent
module cmd_sequencer #(
    parameter int         SPINUP_W = 25,
    parameter logic [7:0] ACK      = 8'hA5,
    parameter logic [7:0] NAK      = 8'hEE
) (
    input  logic               clk,
    input  logic               rst_n,
    cmd_sequencer_if.slave     cif,
    input  logic               cal_done,
    output logic signed [15:0] d_ptch,
    output logic signed [15:0] d_roll,
    output logic signed [15:0] d_yaw,
    output logic [8:0]         thrst,
    output logic               motors_off,
    output logic               inertial_cal,
    output logic               strt_cal
);

    localparam logic [7:0] OP_SET_PTCH  = 8'h02;
    localparam logic [7:0] OP_SET_ROLL  = 8'h03;
    localparam logic [7:0] OP_SET_YAW   = 8'h04;
    localparam logic [7:0] OP_SET_THRST = 8'h05;
    localparam logic [7:0] OP_CALIBRATE = 8'h06;
    localparam logic [7:0] OP_EMER_LAND = 8'h07;
    localparam logic [7:0] OP_MTRS_OFF  = 8'h08;

    localparam logic [SPINUP_W-1:0] CNT_ONE = SPINUP_W'(1);

    typedef enum logic [1:0] {IDLE, SPINUP, CAL, ACK_WAIT} state_t;

    state_t              state_q, state_d;
    logic [SPINUP_W-1:0] spin_cnt;
    logic                decode;
    logic                resp_ld;
    logic [7:0]          resp_byte;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // decode is qualified by rst_n so a held command is never consumed while in reset
    always_comb begin
        state_d   = state_q;
        decode    = 1'b0;
        resp_ld   = 1'b0;
        resp_byte = ACK;
        strt_cal  = 1'b0;
        case (state_q)
            IDLE: begin
                if (cif.cmd_rdy && rst_n) begin
                    decode = 1'b1;
                    if (cif.cmd == OP_CALIBRATE) begin
                        state_d = SPINUP;
                    end else begin
                        resp_ld = 1'b1;
                        if (!(cif.cmd inside {OP_SET_PTCH, OP_SET_ROLL, OP_SET_YAW,
                                              OP_SET_THRST, OP_EMER_LAND, OP_MTRS_OFF}))
                            resp_byte = NAK;
                        state_d = ACK_WAIT;
                    end
                end
            end
            SPINUP: begin
                if (&spin_cnt) begin
                    strt_cal = 1'b1;
                    state_d  = CAL;
                end
            end
            CAL: begin
                if (cal_done) begin
                    resp_ld = 1'b1;
                    state_d = ACK_WAIT;
                end
            end
            ACK_WAIT: begin
                if (cif.resp_sent) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign cif.clr_cmd_rdy = decode;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_ptch        <= '0;
            d_roll        <= '0;
            d_yaw         <= '0;
            thrst         <= '0;
            motors_off    <= 1'b1;
            inertial_cal  <= 1'b0;
            spin_cnt      <= '0;
            cif.send_resp <= 1'b0;
            cif.resp      <= 8'h00;
        end else begin
            cif.send_resp <= resp_ld;
            if (resp_ld) cif.resp <= resp_byte;
            if (state_q == SPINUP) spin_cnt <= spin_cnt + CNT_ONE;
            if (state_q == CAL && cal_done) inertial_cal <= 1'b0;
            if (decode) begin
                case (cif.cmd)
                    OP_SET_PTCH:  d_ptch <= cif.data;
                    OP_SET_ROLL:  d_roll <= cif.data;
                    OP_SET_YAW:   d_yaw  <= cif.data;
                    OP_SET_THRST: thrst  <= cif.data[8:0];
                    OP_CALIBRATE: begin
                        motors_off   <= 1'b0;
                        inertial_cal <= 1'b1;
                        spin_cnt     <= '0;
                    end
                    OP_EMER_LAND: begin
                        d_ptch <= '0;
                        d_roll <= '0;
                        d_yaw  <= '0;
                        thrst  <= '0;
                    end
                    OP_MTRS_OFF:  motors_off <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/cmd_sequencer.md
# cmd_sequencer

Digests 24-bit host commands delivered by the BLE/UART command receiver (`cmd_rdy`, `cmd[7:0]`, `data[15:0]`) and applies them to the flight controller. It holds the pitch/roll/yaw/thrust setpoint registers and sequences motor spin-up and inertial calibration. It returns a one-byte response through the receiver's transmit path (`send_resp`/`resp`/`resp_sent`). It sits between the UART command block and the flight-control/inertial-integrator datapath.

## Interface
- `SPINUP_W`, default 25: width of the spin-up counter. Spin-up lasts 2^SPINUP_W cycles; benches use 9.
- `ACK`, default 8'hA5: positive response byte.
- `NAK`, default 8'hEE: response byte for an unknown opcode.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `cmd_rdy` in 1: a complete command is held on `cmd`/`data`; it stays high until cleared.
- `cmd` in 8: opcode.
- `data` in 16: parameter.
- `clr_cmd_rdy` out 1: one-cycle pulse marking the command as consumed.
- `send_resp` out 1: one-cycle pulse that starts transmission of `resp`.
- `resp` out 8: response byte, registered and held between sends.
- `resp_sent` in 1: response transmission is complete.
- `cal_done` in 1: inertial calibration is complete (pulse).
- `d_ptch` out 16: signed pitch setpoint.
- `d_roll` out 16: signed roll setpoint.
- `d_yaw` out 16: signed yaw setpoint.
- `thrst` out 9: unsigned thrust setpoint.
- `motors_off` out 1: forces the motor drive to zero.
- `inertial_cal` out 1: flight control is in calibration mode (motors at calibration speed).
- `strt_cal` out 1: one-cycle pulse that starts inertial calibration.

## Operation
- Reset values:
  - `d_ptch`, `d_roll`, `d_yaw`, `thrst` = 0.
  - `motors_off` = 1.
  - `inertial_cal`, `strt_cal`, `send_resp`, `clr_cmd_rdy` = 0.
  - `resp` = 8'h00.
  - State = IDLE; spin-up counter = 0.
- States: IDLE, SPINUP, CAL, ACK_WAIT.
- IDLE with `cmd_rdy`=1: `clr_cmd_rdy`=1 combinationally in that cycle, then decode `cmd`:
  - 8'h02 SET_PTCH: `d_ptch` <= `data`.
  - 8'h03 SET_ROLL: `d_roll` <= `data`.
  - 8'h04 SET_YAW: `d_yaw` <= `data`.
  - 8'h05 SET_THRST: `thrst` <= `data[8:0]`; upper bits ignored.
  - 8'h06 CALIBRATE: `motors_off` <= 0, `inertial_cal` <= 1, counter <= 0, next state SPINUP. No response yet.
  - 8'h07 EMER_LAND: all four setpoints <= 0; `motors_off` unchanged.
  - 8'h08 MTRS_OFF: `motors_off` <= 1.
  - Any other opcode: no register change; response is `NAK`.
  - Every opcode except CALIBRATE schedules a response (`ACK` or `NAK`) and goes to ACK_WAIT.
- SPINUP:
  - Counter increments by 1 per cycle.
  - When the counter is all-ones: `strt_cal` pulses one cycle, next state CAL.
- CAL:
  - On `cal_done`=1: `inertial_cal` <= 0, schedule `ACK`, next state ACK_WAIT.
- ACK_WAIT:
  - On `resp_sent`=1: next state IDLE.
- Commands arriving outside IDLE are not consumed; `cmd_rdy` stays high and the command is processed on the first IDLE cycle.
- `resp_sent` outside ACK_WAIT is ignored.
- `cal_done` outside CAL is ignored.
- `cmd_rdy` and `resp_sent` high in the same ACK_WAIT cycle: move to IDLE only; the command is processed in the next cycle.
- `motors_off`=1 does not clear the setpoints.
- A MTRS_OFF received after calibration leaves `inertial_cal` at 0.

## Timing
- Decode cycle N (IDLE, `cmd_rdy`=1):
  - `clr_cmd_rdy`=1 in cycle N.
  - Target register updates at the end of cycle N.
  - `send_resp`=1 in cycle N+1 only.
  - `resp` holds the new byte from cycle N+1 until the next send.
- Calibration, with CALIBRATE decoded in cycle N:
  - `inertial_cal`=1 and `motors_off`=0 from cycle N+1.
  - `strt_cal` is high in cycle N+2^SPINUP_W.
  - `send_resp` is high the cycle after the `cal_done` cycle.
- `send_resp` is never high for two consecutive cycles.
- At most one response is outstanding at any time.
- Asserting reset at any point, including mid-SPINUP, mid-CAL or in ACK_WAIT, returns every output to its reset value immediately. No response is sent after reset is released.

## Test plan
- Reset, then SET_PTCH with `data`=16'hFF80. Required:
  - `clr_cmd_rdy` pulses in the decode cycle.
  - `d_ptch`=16'hFF80 next cycle.
  - `send_resp` one cycle with `resp`=8'hA5.
  - State returns to IDLE only after `resp_sent`.
- SET_THRST with `data`=16'h0FFF. Required: `thrst`=9'h1FF and `ACK`.
- SET_ROLL=16'h0050, SET_YAW=16'h0020, then EMER_LAND. Required: all setpoints 0, one `ACK` per command, `motors_off` unchanged.
- CALIBRATE with `SPINUP_W`=9. Required:
  - `motors_off`=0 and `inertial_cal`=1.
  - `strt_cal` exactly 512 cycles after decode.
  - Held `cmd_rdy` (SET_YAW) is not consumed during SPINUP or CAL.
  - `cal_done` → `ACK`, `inertial_cal`=0.
  - SET_YAW is then processed.
- Opcode 8'h3C. Required: `resp`=8'hEE, no setpoint change. Then MTRS_OFF → `motors_off`=1 and `ACK`.
- Reset asserted mid-SPINUP and released. Required: all outputs at reset values, no `strt_cal` and no `send_resp` afterwards.
